// File: rtl/jtframe_ioctl_dump.sv
// jtframe_ioctl_dump: serves HPS upload reads (ioctl) from core memory.
// Each accepted ioctl_rd launches a fetch on the dump_* port. A per-byte
// wait counter turns a missing dump_ok into 8'hFF. Out-of-range addresses
// answer immediately with all ones.
// Optional macro JTFRAME_MR_WIDEDUMP_EN: fetch a 16-bit word (two bytes)
// per read instead of a single byte.
module jtframe_ioctl_dump #(
  parameter int         AW    = 12,
  parameter logic [7:0] INDEX = 8'd2,
  parameter int         TOUT  = 63
) (
  input  logic          clk_rom,
  input  logic          rst_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [15:0]   ioctl_din,
  output logic [AW-1:0] dump_addr,
  output logic          dump_rd,
  input  logic [7:0]    dump_data,
  input  logic          dump_ok,
  output logic          dump_active,
  output logic          dump_busy,
  output logic          err_tout,
  output logic          err_ovr
);

  // counter counts completed wait cycles; the fetch gives up on the cycle
  // that would make it reach TOUT, so dump_rd is high for TOUT cycles
  localparam int            CW    = (TOUT < 2) ? 1 : $clog2(TOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI} state_t;

  state_t          state_q, state_d;
  logic [15:0]     din_q, din_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            active_q;
  logic            tout_q, tout_d;
  logic            ovr_q, ovr_d;
  logic            tout_set, ovr_set;
  logic            match, rise, oor, tout_hit;
  logic [7:0]      byte_in;
`ifdef JTFRAME_MR_WIDEDUMP_EN
  logic [7:0]      lo_q, lo_d;
`endif

  assign match    = ioctl_upload && (ioctl_index == INDEX);
  assign rise     = match && !active_q;
  assign oor      = |ioctl_addr[24:AW];
  assign tout_hit = !dump_ok && (cnt_q == TLAST);
  assign byte_in  = dump_ok ? dump_data : 8'hFF;

  assign ioctl_din   = din_q;
  assign dump_addr   = addr_q;
  assign dump_rd     = (state_q != IDLE);
  assign dump_busy   = (state_q != IDLE);
  assign dump_active = active_q;
  assign err_tout    = tout_q;
  assign err_ovr     = ovr_q;

  // next state, fetch address, read data and error set requests
  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tout_set = 1'b0;
    ovr_set  = ioctl_rd && (state_q != IDLE);
`ifdef JTFRAME_MR_WIDEDUMP_EN
    lo_d     = lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (ioctl_rd && match) begin
          if (oor) begin
`ifdef JTFRAME_MR_WIDEDUMP_EN
            din_d = 16'hFFFF;
`else
            din_d = 16'h00FF;
`endif
          end else begin
            state_d = REQ_LO;
            cnt_d   = '0;
`ifdef JTFRAME_MR_WIDEDUMP_EN
            addr_d  = {ioctl_addr[AW-1:1], 1'b0};
`else
            addr_d  = ioctl_addr[AW-1:0];
`endif
          end
        end
      end
      REQ_LO: begin
        if (!ioctl_upload) begin
          state_d = IDLE;                // abort, keep old read data
        end else if (dump_ok || tout_hit) begin
          tout_set = !dump_ok;
`ifdef JTFRAME_MR_WIDEDUMP_EN
          lo_d      = byte_in;
          addr_d[0] = 1'b1;
          cnt_d     = '0;
          state_d   = REQ_HI;
`else
          din_d     = {8'h00, byte_in};
          state_d   = IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef JTFRAME_MR_WIDEDUMP_EN
      REQ_HI: begin
        if (!ioctl_upload) begin
          state_d = IDLE;
        end else if (dump_ok || tout_hit) begin
          tout_set = !dump_ok;
          din_d    = {byte_in, lo_q};
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // a new matching session wipes the sticky flags, even over a same-cycle set
    tout_d = rise ? 1'b0 : (tout_q | tout_set);
    ovr_d  = rise ? 1'b0 : (ovr_q  | ovr_set);
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      din_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      tout_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef JTFRAME_MR_WIDEDUMP_EN
      lo_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      active_q <= match;
      tout_q   <= tout_d;
      ovr_q    <= ovr_d;
`ifdef JTFRAME_MR_WIDEDUMP_EN
      lo_q     <= lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtframe_ioctl_dump.sv
// Scoreboard bench for jtframe_ioctl_dump: expected read data is queued when
// a read is issued and compared when the fetch completes.
module tb_jtframe_ioctl_dump;
  localparam int AW = 12;
`ifdef JTFRAME_MR_WIDEDUMP_EN
  localparam bit WIDE = 1'b1;
`else
  localparam bit WIDE = 1'b0;
`endif

  logic          clk_rom = 1'b0;
  logic          rst_n;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [15:0]   ioctl_din;
  logic [AW-1:0] dump_addr;
  logic          dump_rd;
  logic [7:0]    dump_data;
  logic          dump_ok;
  logic          dump_active, dump_busy, err_tout, err_ovr;

  logic [7:0]    mem [0:4095];
  logic          ok_en;
  logic [15:0]   exp_q[$];
  logic [15:0]   last_exp;
  int            errs = 0, checks = 0;

  assign dump_data = mem[dump_addr];
  assign dump_ok   = ok_en;

  always #5 clk_rom = ~clk_rom;

  jtframe_ioctl_dump #(.AW(AW), .INDEX(8'd2), .TOUT(63)) dut (
    .clk_rom(clk_rom), .rst_n(rst_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .dump_addr(dump_addr), .dump_rd(dump_rd),
    .dump_data(dump_data), .dump_ok(dump_ok), .dump_active(dump_active),
    .dump_busy(dump_busy), .err_tout(err_tout), .err_ovr(err_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_rom);
    #1;
  endtask

  function automatic logic [15:0] model(input logic [24:0] a);
    logic [11:0] b;
    b = a[11:0];
    if (a[24:12] != 0) return WIDE ? 16'hFFFF : 16'h00FF;
    if (WIDE) return {mem[{b[11:1], 1'b1}], mem[{b[11:1], 1'b0}]};
    return {8'h00, mem[b]};
  endfunction

  // issue one read, wait for completion, check latency, strobes and data
  task automatic do_read(input string tag, input logic [24:0] a, input int lat, input int rdc_exp);
    int n, rdc;
    logic [AW-1:0] first_a, last_a;
    ioctl_rd = 1'b1; ioctl_addr = a;
    exp_q.push_back(model(a));
    tick;
    ioctl_rd = 1'b0;
    n = 1; rdc = 0;
    first_a = dump_addr; last_a = dump_addr;
    while (dump_busy && n < 400) begin
      if (dump_rd) begin rdc++; last_a = dump_addr; end
      tick; n++;
    end
    chk({tag, " lat"}, n, lat);
    chk({tag, " rdcyc"}, rdc, rdc_exp);
    if (rdc_exp > 0) begin
      chk({tag, " addr0"}, first_a, WIDE ? {a[11:1], 1'b0} : a[11:0]);
      chk({tag, " addr1"}, last_a,  WIDE ? {a[11:1], 1'b1} : a[11:0]);
    end
    last_exp = exp_q.pop_front();
    chk({tag, " din"}, ioctl_din, last_exp);
  endtask

  // wait out an in-flight fetch with a cycle budget
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (dump_busy && n < 400) begin tick; n++; end
    chk({tag, " idle"}, dump_busy, 1'b0);
  endtask

  initial begin
    logic [24:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h123] = 8'h5A; mem[12'h010] = 8'h34; mem[12'h011] = 8'h12;
    rst_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0; ok_en = 1'b1; last_exp = '0;
    tick; tick;
    chk("rst din", ioctl_din, 16'h0);
    chk("rst rd", dump_rd, 1'b0);
    chk("rst busy", dump_busy, 1'b0);
    chk("rst flags", {dump_active, err_tout, err_ovr}, 3'b000);
    rst_n = 1'b1; ioctl_upload = 1'b1; ioctl_index = 8'd2;
    chk("active lat0", dump_active, 1'b0);
    tick;
    chk("active lat1", dump_active, 1'b1);

    // main path, fixed and random addresses plus top-of-range
    do_read("rd123", 25'h123, WIDE ? 3 : 2, WIDE ? 2 : 1);
    do_read("rd010", 25'h010, WIDE ? 3 : 2, WIDE ? 2 : 1);
    for (int i = 0; i < 4; i++) begin
      a = 25'($urandom_range(0, 4095));
      do_read("rdrnd", a, WIDE ? 3 : 2, WIDE ? 2 : 1);
    end
    do_read("rdfff", 25'hFFF, WIDE ? 3 : 2, WIDE ? 2 : 1);
    // out of range: no memory access, answer next cycle
    do_read("oor1000", 25'h1000, 1, 0);
    do_read("oormax", 25'h1FFFFFF, 1, 0);

    // index mismatch: no session, read ignored
    ioctl_index = 8'd3; tick;
    chk("nomatch active", dump_active, 1'b0);
    ioctl_rd = 1'b1; ioctl_addr = 25'h123; tick; ioctl_rd = 1'b0;
    chk("nomatch busy", dump_busy, 1'b0);
    chk("nomatch din", ioctl_din, last_exp);
    ioctl_index = 8'd2; tick;

    // timeout: dump_ok never comes
    ok_en = 1'b0;
    mem[12'h050] = 8'hFF; mem[12'h051] = 8'hFF;
    do_read("tout", 25'h050, WIDE ? 127 : 64, WIDE ? 126 : 63);
    chk("tout flag", err_tout, 1'b1);
    chk("tout noovr", err_ovr, 1'b0);
    ok_en = 1'b1;
    ioctl_upload = 1'b0; tick;
    ioctl_upload = 1'b1; tick;
    chk("tout clear", err_tout, 1'b0);

    // overrun: second read while busy is dropped
    ok_en = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'h200;
    exp_q.push_back(model(25'h200));
    tick;
    ioctl_addr = 25'h300; tick;
    ioctl_rd = 1'b0;
    chk("ovr flag", err_ovr, 1'b1);
    chk("ovr addr", dump_addr, 12'h200);
    ok_en = 1'b1;
    wait_idle("ovr");
    last_exp = exp_q.pop_front();
    chk("ovr din", ioctl_din, last_exp);

    // upload drops mid-fetch: abort, data untouched
    ok_en = 1'b0;
    ioctl_rd = 1'b1; ioctl_addr = 25'h400; tick; ioctl_rd = 1'b0;
    chk("abort busy0", dump_busy, 1'b1);
    ioctl_upload = 1'b0; tick;
    chk("abort busy", dump_busy, 1'b0);
    chk("abort rd", dump_rd, 1'b0);
    chk("abort din", ioctl_din, last_exp);
    ioctl_upload = 1'b1; tick;
    chk("reup ovr clear", err_ovr, 1'b0);

    // reset mid-fetch with a sticky flag set
    ioctl_rd = 1'b1; ioctl_addr = 25'h321; tick;
    tick; ioctl_rd = 1'b0;
    chk("prerst ovr", err_ovr, 1'b1);
    rst_n = 1'b0; tick;
    chk("midrst din", ioctl_din, 16'h0);
    chk("midrst addr", dump_addr, 12'h0);
    chk("midrst rdbusy", {dump_rd, dump_busy}, 2'b00);
    chk("midrst flags", {dump_active, err_tout, err_ovr}, 3'b000);
    rst_n = 1'b1; ok_en = 1'b1; tick;
    do_read("postrst", 25'h123, WIDE ? 3 : 2, WIDE ? 2 : 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
